// File: rtl/mainfsm_pkg.sv
// ============================================================================
// mainfsm_pkg : shared controller types, opcodes and mux-select encodings
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mainfsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRPC   = 4'd12
  } state_e;

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_itype  = 7'b0010011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;

  // SrcA: PC / OldPC / rs1; SrcB: rs2 / imm / 4; Result: ALUOut / Data / ALUResult
  localparam logic [1:0] c_srca_pc     = 2'b00;
  localparam logic [1:0] c_srca_oldpc  = 2'b01;
  localparam logic [1:0] c_srca_rs1    = 2'b10;
  localparam logic [1:0] c_srcb_rs2    = 2'b00;
  localparam logic [1:0] c_srcb_imm    = 2'b01;
  localparam logic [1:0] c_srcb_four   = 2'b10;
  localparam logic [1:0] c_res_aluout  = 2'b00;
  localparam logic [1:0] c_res_data    = 2'b01;
  localparam logic [1:0] c_res_alures  = 2'b10;
  localparam logic [1:0] c_aluop_add   = 2'b00;
  localparam logic [1:0] c_aluop_sub   = 2'b01;
  localparam logic [1:0] c_aluop_funct = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_legal(input logic [6:0] op);
    case (op)
      c_op_load, c_op_store, c_op_rtype, c_op_itype,
      c_op_branch, c_op_jal, c_op_jalr: op_legal = 1'b1;
      default:                          op_legal = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mainfsm_if.sv
// ============================================================================
// mainfsm_if : datapath <-> main controller signal bundle
// Revision   : 1.0
// ============================================================================
`default_nettype none

interface mainfsm_if;
  logic [6:0] op;
  logic       Taken;
  logic       MemReady;
  logic       PCWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ALUOp;
  logic       Illegal;

  // master = datapath side, slave = controller
  modport master (
    output op, Taken, MemReady,
    input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
    input  ALUSrcA, ALUSrcB, ResultSrc, ALUOp, Illegal
  );

  modport slave (
    input  op, Taken, MemReady,
    output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
    output ALUSrcA, ALUSrcB, ResultSrc, ALUOp, Illegal
  );
endinterface

`default_nettype wire

// File: rtl/mainfsm_outdec.sv
// ============================================================================
// mainfsm_outdec : state (+MemReady/Taken/opcode legality) to control outputs
// Revision       : 1.0
// ============================================================================
`default_nettype none

module mainfsm_outdec
  import mainfsm_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  input  logic   taken_i,
  input  logic   op_legal_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.pc_write   = mem_ready_i;
        ctrl_o.ir_write   = mem_ready_i;
        ctrl_o.alu_src_a  = c_srca_pc;
        ctrl_o.alu_src_b  = c_srcb_four;
        ctrl_o.result_src = c_res_alures;
        ctrl_o.alu_op     = c_aluop_add;
      end
      S_DECODE: begin
        ctrl_o.alu_src_a  = c_srca_oldpc;
        ctrl_o.alu_src_b  = c_srcb_imm;
        ctrl_o.alu_op     = c_aluop_add;
        ctrl_o.illegal    = ~op_legal_i;
      end
      S_MEMADR, S_JALR: begin
        ctrl_o.alu_src_a  = c_srca_rs1;
        ctrl_o.alu_src_b  = c_srcb_imm;
        ctrl_o.alu_op     = c_aluop_add;
      end
      S_MEMREAD: begin
        ctrl_o.adr_src    = 1'b1;
        ctrl_o.result_src = c_res_aluout;
      end
      S_MEMWRITE: begin
        ctrl_o.adr_src    = 1'b1;
        ctrl_o.result_src = c_res_aluout;
        ctrl_o.mem_write  = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.result_src = c_res_data;
        ctrl_o.reg_write  = 1'b1;
      end
      S_EXECR: begin
        ctrl_o.alu_src_a  = c_srca_rs1;
        ctrl_o.alu_src_b  = c_srcb_rs2;
        ctrl_o.alu_op     = c_aluop_funct;
      end
      S_EXECI: begin
        ctrl_o.alu_src_a  = c_srca_rs1;
        ctrl_o.alu_src_b  = c_srcb_imm;
        ctrl_o.alu_op     = c_aluop_funct;
      end
      S_ALUWB: begin
        ctrl_o.result_src = c_res_aluout;
        ctrl_o.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a  = c_srca_rs1;
        ctrl_o.alu_src_b  = c_srcb_rs2;
        ctrl_o.alu_op     = c_aluop_sub;
        ctrl_o.result_src = c_res_aluout;
        ctrl_o.pc_write   = taken_i;
      end
      // JAL and JALRPC both load PC from ALUOut while computing the link PC+4
      S_JAL, S_JALRPC: begin
        ctrl_o.alu_src_a  = c_srca_oldpc;
        ctrl_o.alu_src_b  = c_srcb_four;
        ctrl_o.alu_op     = c_aluop_add;
        ctrl_o.result_src = c_res_aluout;
        ctrl_o.pc_write   = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mainfsm.sv
// ============================================================================
// mainfsm : multicycle RISC-V main controller (state register + next state)
// Revision: 1.0
// ============================================================================
`default_nettype none

module mainfsm
  import mainfsm_pkg::*;
(
  input  wire       clk,
  input  wire       reset,
  mainfsm_if.slave  bus
);

  state_e state_q;
  state_e w_state;
  logic   w_op_legal;
  ctrl_t  w_ctrl;

  assign w_op_legal = op_legal(bus.op);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:    if (bus.MemReady) state_q <= S_DECODE;
        S_DECODE: begin
          case (bus.op)
            c_op_load, c_op_store: state_q <= S_MEMADR;
            c_op_rtype:            state_q <= S_EXECR;
            c_op_itype:            state_q <= S_EXECI;
            c_op_branch:           state_q <= S_BRANCH;
            c_op_jal:              state_q <= S_JAL;
            c_op_jalr:             state_q <= S_JALR;
            default:               state_q <= S_FETCH;
          endcase
        end
        S_MEMADR:   state_q <= (bus.op == c_op_load) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (bus.MemReady) state_q <= S_MEMWB;
        S_MEMWRITE: if (bus.MemReady) state_q <= S_FETCH;
        S_MEMWB:    state_q <= S_FETCH;
        S_EXECR:    state_q <= S_ALUWB;
        S_EXECI:    state_q <= S_ALUWB;
        S_ALUWB:    state_q <= S_FETCH;
        S_BRANCH:   state_q <= S_FETCH;
        S_JAL:      state_q <= S_ALUWB;
        S_JALR:     state_q <= S_JALRPC;
        S_JALRPC:   state_q <= S_ALUWB;
        default:    state_q <= S_FETCH;
      endcase
    end
  end

  // While reset is high the outputs already look like FETCH, even before the
  // first edge has loaded the state register.
  assign w_state = reset ? S_FETCH : state_q;

  mainfsm_outdec u_outdec (
    .state_i     (w_state),
    .mem_ready_i (bus.MemReady),
    .taken_i     (bus.Taken),
    .op_legal_i  (w_op_legal),
    .ctrl_o      (w_ctrl)
  );

  assign bus.PCWrite   = w_ctrl.pc_write;
  assign bus.IRWrite   = w_ctrl.ir_write;
  assign bus.RegWrite  = w_ctrl.reg_write;
  assign bus.MemWrite  = w_ctrl.mem_write;
  assign bus.AdrSrc    = w_ctrl.adr_src;
  assign bus.ALUSrcA   = w_ctrl.alu_src_a;
  assign bus.ALUSrcB   = w_ctrl.alu_src_b;
  assign bus.ResultSrc = w_ctrl.result_src;
  assign bus.ALUOp     = w_ctrl.alu_op;
  assign bus.Illegal   = w_ctrl.illegal;

endmodule

`default_nettype wire

// File: tb/tb_mainfsm.sv
// ============================================================================
// tb_mainfsm : directed per-cycle vectors, expected outputs via scoreboard
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_mainfsm;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mainfsm_if bus ();

  mainfsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef enum {T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
                T_EXECR, T_EXECI, T_ALUWB, T_BRANCH, T_JAL, T_JALR, T_JALRPC} tst_e;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] LUI  = 7'b0110111;

  logic [13:0] exp_q[$];
  string       name_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // {PCWrite,IRWrite,RegWrite,MemWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,Illegal}
  function automatic logic [13:0] exp_vec(input tst_e s, input bit mr, input bit tk, input bit ill);
    case (s)
      T_FETCH:    return {mr, mr, 3'b000, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0};
      T_DECODE:   return {5'b00000, 2'b01, 2'b01, 2'b00, 2'b00, ill};
      T_MEMADR:   return {5'b00000, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
      T_MEMREAD:  return {5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      T_MEMWRITE: return {5'b00011, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      T_MEMWB:    return {5'b00100, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0};
      T_EXECR:    return {5'b00000, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0};
      T_EXECI:    return {5'b00000, 2'b10, 2'b01, 2'b00, 2'b10, 1'b0};
      T_ALUWB:    return {5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      T_BRANCH:   return {tk, 4'b0000, 2'b10, 2'b00, 2'b00, 2'b01, 1'b0};
      T_JAL:      return {5'b10000, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0};
      T_JALR:     return {5'b00000, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
      T_JALRPC:   return {5'b10000, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0};
      default:    return '0;
    endcase
  endfunction

  // One clock cycle of stimulus; the expected output for that cycle is queued.
  task automatic cyc(input bit rst, input logic [6:0] o, input bit mr, input bit tk,
                     input tst_e s, input bit ill, input string nm);
    @(posedge clk);
    #1;
    reset        = rst;
    bus.op       = o;
    bus.MemReady = mr;
    bus.Taken    = tk;
    exp_q.push_back(exp_vec(s, mr, tk, ill));
    name_q.push_back(nm);
  endtask

  initial begin : monitor
    logic [13:0] got;
    logic [13:0] exp;
    string       nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        got = {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.AdrSrc,
               bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUOp, bus.Illegal};
        n_cmp++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
      end
    end
  end

  initial begin : stim
    reset = 1'b1; bus.op = '0; bus.MemReady = 1'b0; bus.Taken = 1'b0;

    cyc(1, LW, 0, 0, T_FETCH, 0, "rst_mr0");
    cyc(1, LW, 1, 0, T_FETCH, 0, "rst_mr1");
    cyc(0, LW, 0, 0, T_FETCH, 0, "fetch_wait0");
    cyc(0, LW, 0, 0, T_FETCH, 0, "fetch_wait1");

    // lw: 5 cycles, RegWrite only in MEMWB
    cyc(0, LW, 1, 0, T_FETCH,   0, "lw_fetch");
    cyc(0, LW, 1, 0, T_DECODE,  0, "lw_decode");
    cyc(0, LW, 1, 0, T_MEMADR,  0, "lw_memadr");
    cyc(0, LW, 1, 0, T_MEMREAD, 0, "lw_memread");
    cyc(0, LW, 1, 0, T_MEMWB,   0, "lw_memwb");

    // sw with memory stalled 3 cycles
    cyc(0, SW, 1, 0, T_FETCH,    0, "sw_fetch");
    cyc(0, SW, 1, 0, T_DECODE,   0, "sw_decode");
    cyc(0, SW, 1, 0, T_MEMADR,   0, "sw_memadr");
    cyc(0, SW, 0, 0, T_MEMWRITE, 0, "sw_wait1");
    cyc(0, SW, 0, 0, T_MEMWRITE, 0, "sw_wait2");
    cyc(0, SW, 0, 0, T_MEMWRITE, 0, "sw_wait3");
    cyc(0, SW, 1, 0, T_MEMWRITE, 0, "sw_done");

    cyc(0, RT, 1, 0, T_FETCH,  0, "r_fetch");
    cyc(0, RT, 1, 0, T_DECODE, 0, "r_decode");
    cyc(0, RT, 1, 0, T_EXECR,  0, "r_exec");
    cyc(0, RT, 1, 0, T_ALUWB,  0, "r_aluwb");

    cyc(0, IT, 1, 0, T_FETCH,  0, "i_fetch");
    cyc(0, IT, 1, 0, T_DECODE, 0, "i_decode");
    cyc(0, IT, 1, 0, T_EXECI,  0, "i_exec");
    cyc(0, IT, 1, 0, T_ALUWB,  0, "i_aluwb");

    cyc(0, BEQ, 1, 0, T_FETCH,  0, "bnt_fetch");
    cyc(0, BEQ, 1, 0, T_DECODE, 0, "bnt_decode");
    cyc(0, BEQ, 1, 0, T_BRANCH, 0, "bnt_branch");
    cyc(0, BEQ, 1, 0, T_FETCH,  0, "bt_fetch");
    cyc(0, BEQ, 1, 0, T_DECODE, 0, "bt_decode");
    cyc(0, BEQ, 1, 1, T_BRANCH, 0, "bt_branch");

    cyc(0, JAL, 1, 0, T_FETCH,  0, "jal_fetch");
    cyc(0, JAL, 1, 0, T_DECODE, 0, "jal_decode");
    cyc(0, JAL, 1, 0, T_JAL,    0, "jal_jal");
    cyc(0, JAL, 1, 0, T_ALUWB,  0, "jal_aluwb");

    cyc(0, JALR, 1, 0, T_FETCH,  0, "jalr_fetch");
    cyc(0, JALR, 1, 0, T_DECODE, 0, "jalr_decode");
    cyc(0, JALR, 1, 0, T_JALR,   0, "jalr_jalr");
    cyc(0, JALR, 1, 0, T_JALRPC, 0, "jalr_jalrpc");
    cyc(0, JALR, 1, 0, T_ALUWB,  0, "jalr_aluwb");

    // unsupported opcode: Illegal only in DECODE, straight back to FETCH
    cyc(0, LUI, 1, 0, T_FETCH,  0, "ill_fetch");
    cyc(0, LUI, 1, 0, T_DECODE, 1, "ill_decode");
    cyc(0, LUI, 0, 0, T_FETCH,  0, "ill_back");

    // reset while MEMREAD is stalled
    cyc(0, LW, 1, 0, T_FETCH,   0, "rr_fetch");
    cyc(0, LW, 1, 0, T_DECODE,  0, "rr_decode");
    cyc(0, LW, 1, 0, T_MEMADR,  0, "rr_memadr");
    cyc(0, LW, 0, 0, T_MEMREAD, 0, "rr_memread");
    cyc(1, LW, 0, 0, T_FETCH,   0, "rr_in_reset");
    cyc(0, LW, 0, 0, T_FETCH,   0, "rr_after");

    // reset while MEMWRITE is stalled
    cyc(0, SW, 1, 0, T_FETCH,    0, "rw_fetch");
    cyc(0, SW, 1, 0, T_DECODE,   0, "rw_decode");
    cyc(0, SW, 1, 0, T_MEMADR,   0, "rw_memadr");
    cyc(0, SW, 0, 0, T_MEMWRITE, 0, "rw_memwrite");
    cyc(1, SW, 1, 0, T_FETCH,    0, "rw_in_reset");
    cyc(0, SW, 0, 0, T_FETCH,    0, "rw_after");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
